multicycle_control_fsm: RTL and testbench

- Multi-cycle control sequencer for the RV32I datapath.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB over a shared instruction/data memory port.
- Emits the same control set as the single-cycle decoder (branch, MemRead, MemtoReg, MemWrite, ALUScr, RegWrite, ALUOp_out), plus sequencing strobes and a memory request/ready handshake with timeout.
- Sits between the instruction register and the datapath muxes and enables.

---
 rtl/multicycle_control_fsm.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB
// over a shared memory port with request timeout and trap pulses.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OPcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       pc_write,
  output logic       ir_write,
  output logic       branch,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic       MemWrite,
  output logic       ALUScr,
  output logic       RegWrite,
  output logic [1:0] ALUOp_out,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_ILL  = 2'd1,
    C_BUS  = 2'd2
  } cause_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  cause_t           cause;
  logic [6:0]       op;
  logic [CNT_W-1:0] cnt;

  logic is_r, is_i, is_ld, is_st, is_br;
  logic in_ok;

  assign is_r  = (op == OP_R);
  assign is_i  = (op == OP_I);
  assign is_ld = (op == OP_LD);
  assign is_st = (op == OP_ST);
  assign is_br = (op == OP_BR);

  assign in_ok = (OPcode == OP_R)  || (OPcode == OP_I) ||
                 (OPcode == OP_LD) || (OPcode == OP_ST) ||
                 (OPcode == OP_BR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      op    <= '0;
      cnt   <= '0;
      cause <= C_NONE;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            state <= DECODE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= TRAP;
            cause <= C_BUS;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DECODE: begin
          op <= OPcode;
          if (in_ok) begin
            state <= EXEC;
          end else begin
            state <= TRAP;
            cause <= C_ILL;
          end
        end
        EXEC: begin
          cnt <= '0;
          if (is_r || is_i)       state <= WB;
          else if (is_ld || is_st) state <= MEM;
          else                    state <= FETCH;
        end
        MEM: begin
          if (mem_ready) begin
            state <= is_ld ? WB : FETCH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= TRAP;
            cause <= C_BUS;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB:      state <= FETCH;
        TRAP:    state <= FETCH;
        default: begin
          state <= FETCH;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs decode straight from state; reset masks everything.
  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    branch     = 1'b0;
    MemRead    = 1'b0;
    MemtoReg   = 1'b0;
    MemWrite   = 1'b0;
    ALUScr     = 1'b0;
    RegWrite   = 1'b0;
    ALUOp_out  = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    state_out  = 3'd0;
    if (!reset) begin
      state_out = state;
      case (state)
        FETCH: begin
          mem_req  = 1'b1;
          MemRead  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        EXEC: begin
          unique case (1'b1)
            is_r: ALUOp_out = 2'b10;
            is_i: begin
              ALUOp_out = 2'b11;
              ALUScr    = 1'b1;
            end
            is_ld, is_st: ALUScr = 1'b1;
            is_br: begin
              ALUOp_out  = 2'b01;
              branch     = 1'b1;
              instr_done = 1'b1;
            end
            default: ALUOp_out = 2'b00;
          endcase
        end
        MEM: begin
          mem_req    = 1'b1;
          IorD       = 1'b1;
          ALUScr     = 1'b1;
          MemRead    = is_ld;
          MemWrite   = is_st;
          instr_done = is_st && mem_ready;
        end
        WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = is_ld;
          instr_done = 1'b1;
        end
        TRAP: begin
          illegal = (cause == C_ILL);
          bus_err = (cause == C_BUS);
        end
        default: state_out = state;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm (MEM_TIMEOUT=4).
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] OPcode;
  logic       mem_ready;
  logic       mem_req, IorD, pc_write, ir_write, branch;
  logic       MemRead, MemtoReg, MemWrite, ALUScr, RegWrite;
  logic [1:0] ALUOp_out;
  logic       instr_done, illegal, bus_err;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(
    .MEM_TIMEOUT(4),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .OPcode(OPcode),
    .mem_ready(mem_ready),
    .mem_req(mem_req),
    .IorD(IorD),
    .pc_write(pc_write),
    .ir_write(ir_write),
    .branch(branch),
    .MemRead(MemRead),
    .MemtoReg(MemtoReg),
    .MemWrite(MemWrite),
    .ALUScr(ALUScr),
    .RegWrite(RegWrite),
    .ALUOp_out(ALUOp_out),
    .instr_done(instr_done),
    .illegal(illegal),
    .bus_err(bus_err),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {mem_req, IorD, pc_write, ir_write, branch,
                MemRead, MemtoReg, MemWrite, ALUScr, RegWrite,
                ALUOp_out, instr_done, illegal, bus_err, state_out};

  localparam logic [17:0] REQ  = 18'h20000;
  localparam logic [17:0] IORD = 18'h10000;
  localparam logic [17:0] PCW  = 18'h08000;
  localparam logic [17:0] IRW  = 18'h04000;
  localparam logic [17:0] BR   = 18'h02000;
  localparam logic [17:0] MRD  = 18'h01000;
  localparam logic [17:0] M2R  = 18'h00800;
  localparam logic [17:0] MWR  = 18'h00400;
  localparam logic [17:0] SRC  = 18'h00200;
  localparam logic [17:0] RW   = 18'h00100;
  localparam logic [17:0] A10  = 18'h00080;
  localparam logic [17:0] A11  = 18'h000C0;
  localparam logic [17:0] A01  = 18'h00040;
  localparam logic [17:0] DONE = 18'h00020;
  localparam logic [17:0] ILL  = 18'h00010;
  localparam logic [17:0] BERR = 18'h00008;
  localparam logic [17:0] FOK  = REQ | PCW | IRW | MRD;
  localparam logic [17:0] FW   = REQ | MRD;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] L  = 7'b0000011;
  localparam logic [6:0] S  = 7'b0100011;
  localparam logic [6:0] B  = 7'b1100011;
  localparam logic [6:0] X  = 7'b1111111;

  typedef struct packed {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  function automatic vec_t mk(logic r, logic [6:0] o,
                              logic y, logic [17:0] e);
    mk = '{rst: r, op: o, rdy: y, exp: e};
  endfunction

  task automatic step(vec_t v);
    @(negedge clk);
    reset     = v.rst;
    OPcode    = v.op;
    mem_ready = v.rdy;
    #1;
  endtask

  task automatic test_reset;
    vec_t v[$];
    v.push_back(mk(1, R, 1, 18'h0));
    v.push_back(mk(1, X, 1, 18'h0));
    for (int i = 0; i < v.size(); i++) begin
      step(v[i]);
      checks++;
      if (obs !== v[i].exp) begin
        $display("FAIL reset[%0d] got %h want %h", i, obs, v[i].exp);
        errors++;
      end
    end
  endtask

  task automatic test_rtype;
    vec_t v[$];
    v.push_back(mk(0, R, 1, FOK));
    v.push_back(mk(0, R, 1, 18'd1));
    v.push_back(mk(0, R, 1, A10 | 18'd2));
    v.push_back(mk(0, R, 1, RW | DONE | 18'd4));
    v.push_back(mk(0, I, 1, FOK));
    v.push_back(mk(0, I, 1, 18'd1));
    v.push_back(mk(0, I, 1, A11 | SRC | 18'd2));
    v.push_back(mk(0, I, 1, RW | DONE | 18'd4));
    for (int i = 0; i < v.size(); i++) begin
      step(v[i]);
      checks++;
      if (obs !== v[i].exp) begin
        $display("FAIL rtype[%0d] got %h want %h", i, obs, v[i].exp);
        errors++;
      end
    end
  endtask

  task automatic test_load_wait;
    vec_t v[$];
    v.push_back(mk(0, L, 1, FOK));
    v.push_back(mk(0, L, 1, 18'd1));
    v.push_back(mk(0, L, 1, SRC | 18'd2));
    v.push_back(mk(0, L, 0, REQ | IORD | MRD | SRC | 18'd3));
    v.push_back(mk(0, L, 0, REQ | IORD | MRD | SRC | 18'd3));
    v.push_back(mk(0, L, 1, REQ | IORD | MRD | SRC | 18'd3));
    v.push_back(mk(0, L, 0, RW | M2R | DONE | 18'd4));
    for (int i = 0; i < v.size(); i++) begin
      step(v[i]);
      checks++;
      if (obs !== v[i].exp) begin
        $display("FAIL load[%0d] got %h want %h", i, obs, v[i].exp);
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[$];
    v.push_back(mk(0, S, 1, FOK));
    v.push_back(mk(0, S, 1, 18'd1));
    v.push_back(mk(0, S, 1, SRC | 18'd2));
    v.push_back(mk(0, S, 1, REQ | IORD | MWR | SRC | DONE | 18'd3));
    v.push_back(mk(0, B, 1, FOK));
    v.push_back(mk(0, B, 1, 18'd1));
    v.push_back(mk(0, B, 1, BR | A01 | DONE | 18'd2));
    for (int i = 0; i < v.size(); i++) begin
      step(v[i]);
      checks++;
      if (obs !== v[i].exp) begin
        $display("FAIL b2b[%0d] got %h want %h", i, obs, v[i].exp);
        errors++;
      end
    end
  endtask

  task automatic test_illegal;
    vec_t v[$];
    v.push_back(mk(0, X, 1, FOK));
    v.push_back(mk(0, X, 1, 18'd1));
    v.push_back(mk(0, X, 1, ILL | 18'd5));
    v.push_back(mk(0, B, 1, FOK));
    v.push_back(mk(0, B, 0, 18'd1));
    v.push_back(mk(0, B, 0, BR | A01 | DONE | 18'd2));
    for (int i = 0; i < v.size(); i++) begin
      step(v[i]);
      checks++;
      if (obs !== v[i].exp) begin
        $display("FAIL illegal[%0d] got %h want %h", i, obs, v[i].exp);
        errors++;
      end
    end
  endtask

  task automatic test_timeout;
    vec_t v[$];
    for (int k = 0; k < 4; k++) v.push_back(mk(0, R, 0, FW));
    v.push_back(mk(0, R, 0, BERR | 18'd5));
    v.push_back(mk(0, R, 1, FOK));
    v.push_back(mk(0, R, 1, 18'd1));
    v.push_back(mk(0, R, 1, A10 | 18'd2));
    v.push_back(mk(0, R, 1, RW | DONE | 18'd4));
    for (int k = 0; k < 3; k++) v.push_back(mk(0, R, 0, FW));
    v.push_back(mk(0, R, 1, FOK));
    v.push_back(mk(0, R, 0, 18'd1));
    v.push_back(mk(0, R, 0, A10 | 18'd2));
    v.push_back(mk(0, R, 0, RW | DONE | 18'd4));
    for (int i = 0; i < v.size(); i++) begin
      step(v[i]);
      checks++;
      if (obs !== v[i].exp) begin
        $display("FAIL timeout[%0d] got %h want %h", i, obs, v[i].exp);
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid;
    vec_t v[$];
    v.push_back(mk(0, S, 1, FOK));
    v.push_back(mk(0, S, 1, 18'd1));
    v.push_back(mk(0, S, 1, SRC | 18'd2));
    v.push_back(mk(0, S, 0, REQ | IORD | MWR | SRC | 18'd3));
    v.push_back(mk(0, S, 0, REQ | IORD | MWR | SRC | 18'd3));
    v.push_back(mk(1, S, 1, 18'h0));
    for (int k = 0; k < 4; k++) v.push_back(mk(0, S, 0, FW));
    v.push_back(mk(0, S, 0, BERR | 18'd5));
    v.push_back(mk(0, S, 1, FOK));
    for (int i = 0; i < v.size(); i++) begin
      step(v[i]);
      checks++;
      if (obs !== v[i].exp) begin
        $display("FAIL rstmid[%0d] got %h want %h", i, obs, v[i].exp);
        errors++;
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    OPcode    = 7'd0;
    mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
